// File: rtl/phase_addr_gen_pkg.sv
// rtl/phase_addr_gen_pkg.sv - shared types, default widths and addr2 helper for phase_addr_gen
// Contents:
//   state_t   : controller states IDLE / RUN / BURST
//   DEF_*     : default parameter values for the generator, interface and counter
//   addr2_of  : raw sum addr1 + offset; the caller truncates it to its address width
package phase_addr_gen_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_FRAC_WIDTH    = 8;
  localparam int DEF_BURST_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  // Returned at full width; truncating to the ROM address width gives the
  // modulo-2^ADDRESS_WIDTH wraparound.
  function automatic logic [31:0] addr2_of(input logic [31:0] addr1,
                                           input logic [31:0] offset);
    return addr1 + offset;
  endfunction

endpackage

// File: rtl/phase_addr_gen_if.sv
// rtl/phase_addr_gen_if.sv - control and address bus of the phase accumulator address generator
// Signals (master = controller side, slave = phase_addr_gen):
//   en, clear, cfg_load, incr, offset, burst_start, burst_len : master -> slave
//   addr1, addr2, addr_valid, wrap, busy, done                : slave -> master
interface phase_addr_gen_if
  import phase_addr_gen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FRAC_WIDTH    = DEF_FRAC_WIDTH,
  parameter int BURST_WIDTH   = DEF_BURST_WIDTH
);

  logic                                en;
  logic                                clear;
  logic                                cfg_load;
  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr;
  logic [ADDRESS_WIDTH-1:0]            offset;
  logic                                burst_start;
  logic [BURST_WIDTH-1:0]              burst_len;
  logic [ADDRESS_WIDTH-1:0]            addr1;
  logic [ADDRESS_WIDTH-1:0]            addr2;
  logic                                addr_valid;
  logic                                wrap;
  logic                                busy;
  logic                                done;

  modport master (
    output en, clear, cfg_load, incr, offset, burst_start, burst_len,
    input  addr1, addr2, addr_valid, wrap, busy, done
  );

  modport slave (
    input  en, clear, cfg_load, incr, offset, burst_start, burst_len,
    output addr1, addr2, addr_valid, wrap, busy, done
  );

endinterface

// File: rtl/phase_addr_gen_burst_counter.sv
// rtl/phase_addr_gen_burst_counter.sv - loadable burst step down-counter with zero/one flags
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : burst length to load
//   dec_i       : decrement by one; saturates at zero
//   zero_o      : count is zero
//   one_o       : count is one, i.e. the next decrement is the final step
module burst_counter
  import phase_addr_gen_pkg::*;
#(
  parameter int WIDTH = DEF_BURST_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/phase_addr_gen.sv
// rtl/phase_addr_gen.sv - phase accumulator address generator for a dual-read sine ROM
// Optional build macro PHASE_ROUND_EN: addr1 rounds the accumulator to nearest
// instead of truncating it; wrap still follows the unrounded accumulator carry.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : phase_addr_gen_if slave; controls in, addr1/addr2/addr_valid/wrap/busy/done out
module phase_addr_gen
  import phase_addr_gen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int FRAC_WIDTH    = DEF_FRAC_WIDTH,
  parameter int BURST_WIDTH   = DEF_BURST_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  phase_addr_gen_if.slave  bus
);

  localparam int ACC_W = ADDRESS_WIDTH + FRAC_WIDTH;

  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [ACC_W-1:0]         incr_q, incr_d;
  logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
  logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
  logic                     valid_q, wrap_q, done_q, done_d;
  logic [ACC_W-1:0]         step_sum;
  logic                     step_carry;
  logic                     adv;
  logic                     burst_load;
  logic                     cnt_zero, cnt_one;

  burst_counter #(.WIDTH(BURST_WIDTH)) u_burst_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (burst_load),
    .load_val_i (bus.burst_len),
    .dec_i      (adv && (state_q == BURST)),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  // The step always uses the registered tuning word, so a coincident
  // cfg_load only takes effect from the following step.
  assign {step_carry, step_sum} = {1'b0, acc_q} + {1'b0, incr_q};

  // adv is a step that actually lands; clear suppresses it, and in BURST a
  // suppressed step neither counts down nor ends the burst.
  always_comb begin
    state_d    = state_q;
    adv        = 1'b0;
    burst_load = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.burst_start && (bus.burst_len != '0)) begin
          state_d    = BURST;
          burst_load = 1'b1;
        end else if (bus.en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (!bus.clear) begin
          adv = 1'b1;
        end
      end
      BURST: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else if (!bus.clear) begin
          adv = 1'b1;
          if (cnt_one) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign incr_d   = bus.cfg_load ? bus.incr   : incr_q;
  assign offset_d = bus.cfg_load ? bus.offset : offset_q;
  assign acc_d    = bus.clear ? '0 : (adv ? step_sum : acc_q);

`ifdef PHASE_ROUND_EN
  localparam logic [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (FRAC_WIDTH - 1));
  logic [ACC_W-1:0] acc_rnd;
  assign acc_rnd = acc_d + HALF_LSB;
  assign addr1_d = acc_rnd[ACC_W-1:FRAC_WIDTH];
`else
  assign addr1_d = acc_d[ACC_W-1:FRAC_WIDTH];
`endif

  // addr2 tracks addr1 + offset on every edge, so a new offset shows up
  // immediately even when no step happens.
  assign addr2_d = ADDRESS_WIDTH'(addr2_of(32'(addr1_d), 32'(offset_d)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      incr_q   <= '0;
      offset_q <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      incr_q   <= incr_d;
      offset_q <= offset_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      valid_q  <= adv;
      wrap_q   <= adv && step_carry;
      done_q   <= done_d;
    end
  end

  assign bus.addr1      = addr1_q;
  assign bus.addr2      = addr2_q;
  assign bus.addr_valid = valid_q;
  assign bus.wrap       = wrap_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_phase_addr_gen.sv
// tb/tb_phase_addr_gen.sv - scoreboard testbench for phase_addr_gen
module tb_phase_addr_gen;

  logic clk;
  logic rst_n;

  phase_addr_gen_if bus ();

  phase_addr_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic       w;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done = 0;
  int   checks   = 0;
  int   failures = 0;
  int   frac_exp[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] a1, input logic [7:0] a2, input logic w);
    exp_t e;
    e.a1 = a1;
    e.a2 = a2;
    e.w  = w;
    exp_q.push_back(e);
  endtask

  // Monitor: every advance must match the head of the scoreboard; every done
  // pulse must have been announced by the stimulus.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wrap_without_valid", 32'(bus.wrap & ~bus.addr_valid), 32'd0);
      if (bus.addr_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("addr1", 32'(bus.addr1), 32'(e.a1));
          chk("addr2", 32'(bus.addr2), 32'(e.a2));
          chk("wrap",  32'(bus.wrap),  32'(e.w));
        end
      end
      if (bus.done) begin
        if (exp_done == 0) chk("unexpected_done", 32'd1, 32'd0);
        else exp_done--;
      end
    end
  end

  task automatic cfg(input logic [15:0] incr, input logic [7:0] off);
    bus.cfg_load = 1'b1;
    bus.incr     = incr;
    bus.offset   = off;
    @(negedge clk);
    bus.cfg_load = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic start_burst(input logic [15:0] len);
    bus.burst_start = 1'b1;
    bus.burst_len   = len;
    @(negedge clk);
    bus.burst_start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.done && t < 100);
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic wait_valids(input int n, input string name);
    int v, t;
    v = 0;
    t = 0;
    while (v < n && t < 50) begin
      @(negedge clk);
      t++;
      if (bus.addr_valid) v++;
    end
    chk(name, 32'(v), 32'(n));
  endtask

  initial begin
`ifdef PHASE_ROUND_EN
    frac_exp = '{1, 1, 2, 2};
`else
    frac_exp = '{0, 1, 1, 2};
`endif
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.clear       = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.incr        = '0;
    bus.offset      = '0;
    bus.burst_start = 1'b0;
    bus.burst_len   = '0;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_addr1", 32'(bus.addr1), 32'd0);
    chk("rst_addr2", 32'(bus.addr2), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_valid", 32'(bus.addr_valid), 32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);

    // Free-run, four steps
    cfg(16'h0100, 8'h40);
    chk("cfg_addr2_now", 32'(bus.addr2), 32'h40);
    for (int i = 1; i <= 4; i++) push(8'(i), 8'(8'h40 + i), 1'b0);
    bus.en = 1'b1;
    wait_valids(4, "run_steps");
    bus.en = 1'b0;
    @(negedge clk);
    chk("run_stop_busy",  32'(bus.busy), 32'd0);
    chk("run_stop_valid", 32'(bus.addr_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("run_hold_addr1", 32'(bus.addr1), 32'd4);

    // Wrap: reach acc=0xFE00, then step by 0x0300
    pulse_clear();
    chk("clr_addr1", 32'(bus.addr1), 32'd0);
    chk("clr_addr2", 32'(bus.addr2), 32'h40);
    cfg(16'hFE00, 8'h40);
    push(8'hFE, 8'h3E, 1'b0);
    exp_done++;
    start_burst(16'd1);
    wait_done();
    cfg(16'h0300, 8'h40);
    push(8'h01, 8'h41, 1'b1);
    exp_done++;
    start_burst(16'd1);
    wait_done();
    chk("wrap_addr1", 32'(bus.addr1), 32'h01);

    // Fractional rate
    pulse_clear();
    cfg(16'h0080, 8'h40);
    for (int i = 0; i < 4; i++) push(8'(frac_exp[i]), 8'(8'h40 + frac_exp[i]), 1'b0);
    exp_done++;
    start_burst(16'd4);
    wait_done();

    // Burst of 5, burst_start beats en in IDLE
    pulse_clear();
    cfg(16'h0100, 8'h40);
    for (int i = 1; i <= 5; i++) push(8'(i), 8'(8'h40 + i), 1'b0);
    exp_done++;
    bus.en = 1'b1;
    start_burst(16'd5);
    bus.en = 1'b0;
    begin
      int b, t;
      b = 0;
      t = 0;
      while (bus.busy && t < 50) begin
        b++;
        t++;
        @(negedge clk);
      end
      chk("burst_busy_cycles", 32'(b), 32'd5);
    end
    chk("burst_done_pulse", 32'(bus.done), 32'd1);
    chk("burst_end_addr1",  32'(bus.addr1), 32'd5);
    repeat (3) @(negedge clk);
    chk("burst_hold_addr1", 32'(bus.addr1), 32'd5);
    chk("burst_idle_busy",  32'(bus.busy), 32'd0);

    // Zero-length burst is ignored
    start_burst(16'd0);
    @(negedge clk);
    chk("zero_len_busy", 32'(bus.busy), 32'd0);

    // Reset at step 2 of a 10-step burst
    pulse_clear();
    push(8'h01, 8'h41, 1'b0);
    push(8'h02, 8'h42, 1'b0);
    start_burst(16'd10);
    wait_valids(2, "mid_burst_steps");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_addr1", 32'(bus.addr1), 32'd0);
    chk("arst_addr2", 32'(bus.addr2), 32'd0);
    chk("arst_valid", 32'(bus.addr_valid), 32'd0);
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_done",  32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("arst_no_done", 32'(bus.done), 32'd0);
    end

    // Clear during RUN
    cfg(16'h0100, 8'h40);
    push(8'h01, 8'h41, 1'b0);
    push(8'h02, 8'h42, 1'b0);
    push(8'h01, 8'h41, 1'b0);
    bus.en = 1'b1;
    wait_valids(2, "pre_clear_steps");
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("runclr_addr1", 32'(bus.addr1), 32'd0);
    chk("runclr_addr2", 32'(bus.addr2), 32'h40);
    chk("runclr_valid", 32'(bus.addr_valid), 32'd0);
    chk("runclr_busy",  32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    chk("runclr_stop_busy", 32'(bus.busy), 32'd0);
    chk("runclr_end_addr1", 32'(bus.addr1), 32'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("done_outstanding", 32'(exp_done), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
